instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Boot-time writer for the instruction memory load port. It takes a byte stream (valid/ready) from a host link such as a UART receiver or debug bridge and parses a length-prefixed image. It assembles little-endian 32-bit words and issues one write per word to the instruction memory load interface. While loading, it holds the core stalled.

Parameters:
width_p, 32, instruction word width; fixed at 32 (4 bytes per word)
depth_p, 1024, instruction memory depth in words; sets the address width and the maximum image size
base_addr_p, 0, byte address of the first word written; must be a multiple of 4

Ports:
clk_i  input  1  clock
reset_ni  input  1  asynchronous active-low reset
start_i  input  1  begin a load session (one-cycle pulse)
abort_i  input  1  cancel the current session
byte_valid_i  input  1  byte_data_i is valid
byte_data_i  input  8  incoming byte
byte_ready_o  output  1  loader accepts a byte this cycle
load_enable_o  output  1  write strobe to instruction memory
load_addr_o  output  $clog2(depth_p*4)  byte address of the write
load_data_o  output  width_p  word to write
busy_o  output  1  session in progress; drives the core stall
done_o  output  1  one-cycle pulse on successful completion
error_o  output  1  sticky flag: image length exceeds capacity

Behaviour:
- Single clock. reset_ni low asynchronously forces the following:
  - state IDLE;
  - all outputs 0, load_addr_o = 0;
  - internal byte index, word count and remaining counter cleared.
- A byte is accepted only on a cycle where byte_valid_i && byte_ready_o. byte_ready_o depends only on state; it does not depend on byte_valid_i.
- Byte assembly: byte k (k = 0..3) of a group lands in bits [8k+7:8k]. A 2-bit index increments per accepted byte and wraps 3 -> 0.
- States:
  - IDLE: byte_ready_o = 0. start_i -> LEN, index = 0, addr = base_addr_p.
  - LEN: byte_ready_o = 1; collects a 32-bit word count N. On the 4th accepted byte:
    - N == 0 -> DONE;
    - N > depth_p - base_addr_p/4 -> ERR;
    - otherwise -> DATA with remaining = N.
  - DATA: byte_ready_o = 1; collects 4 bytes into the data register. The 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle. load_enable_o = 1, load_data_o = assembled word, load_addr_o = current addr, byte_ready_o = 0. Next cycle: addr += 4, remaining -= 1; remaining reaching 0 -> DONE, else -> DATA.
  - DONE: done_o = 1 for one cycle -> IDLE.
  - ERR: error_o = 1 (sticky), byte_ready_o = 0, no writes. start_i clears error_o and -> LEN. reset also clears it.
- busy_o = 1 in LEN, DATA and WRITE; 0 in IDLE, DONE and ERR.
- load_enable_o is asserted only in WRITE. load_addr_o and load_data_o are registered and hold their last values outside WRITE.
- Address never exceeds the memory: the ERR check guarantees the last write address is at most (depth_p-1)*4.
- start_i while busy_o = 1: ignored.
- abort_i while busy_o = 1: next state IDLE, index cleared, error_o unchanged, done_o not pulsed.
  - Abort has priority over byte acceptance in the same cycle.
  - Abort in WRITE: that cycle's write still occurs (load_enable_o already registered), then IDLE.
- abort_i in IDLE, DONE or ERR: no effect.
- start_i and abort_i asserted together in IDLE: start wins.
- Stalls on byte_valid_i mid-word: state and partial data hold indefinitely; there is no timeout.
- Throughput: one word per 5 cycles with bytes back-to-back (4 accepts + 1 WRITE).

Test Plan:
1. Reset then start_i; stream 02 00 00 00, 13 00 00 00, 93 00 10 00 back-to-back -> writes (addr 0x000, data 0x00000013) then (addr 0x004, data 0x00100093); each load_enable_o lasts one cycle; done_o pulses once; busy_o high from the cycle after start to WRITE of word 2.
2. Length 00 00 00 00 -> no load_enable_o; done_o pulses 5 cycles after the start_i cycle; busy_o returns to 0.
3. depth_p = 16, length 11 00 00 00 (17) -> error_o = 1, busy_o = 0, no writes. Later start_i with length 01 00 00 00 and one word -> error_o clears, single write to addr 0.
4. Insert random byte_valid_i gaps (including 10 idle cycles between bytes 2 and 3 of a word) -> identical write sequence to scenario 1; byte_ready_o stays 1 throughout gaps.
5. abort_i after 2 data bytes of word 1 -> no write, back to IDLE, done_o = 0. Subsequent full session writes from base_addr_p with fresh byte alignment.
6. Drive reset_ni low mid-DATA, asynchronously between clock edges -> all outputs 0 immediately. After release, state is IDLE and byte_ready_o = 0 until start_i.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed little-endian
// byte stream and writes one 32-bit word per group of four data bytes.
module instruction_loader #(
  parameter int width_p     = 32,
  parameter int depth_p     = 1024,
  parameter int base_addr_p = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          byte_valid_i,
  input  logic [7:0]                    byte_data_i,
  output logic                          byte_ready_o,
  output logic                          load_enable_o,
  output logic [$clog2(depth_p*4)-1:0]  load_addr_o,
  output logic [width_p-1:0]            load_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  localparam int               AddrW    = $clog2(depth_p*4);
  localparam int               RemW     = $clog2(depth_p+1);
  localparam logic [31:0]      Capacity = 32'(depth_p - base_addr_p/4);
  localparam logic [AddrW-1:0] BaseAddr = AddrW'(base_addr_p);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q;
  logic [width_p-1:0] asm_q;
  logic [RemW-1:0]    rem_q;
  logic [AddrW-1:0]   addr_q;
  logic [AddrW-1:0]   load_addr_q;
  logic [width_p-1:0] load_data_q;
  logic               error_q;

  logic               in_busy;
  logic               take;
  logic               last_byte;
  logic               start_ok;
  logic [31:0]        len_word;

  assign in_busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
  // Abort wins over a byte offered in the same cycle.
  assign take         = byte_valid_i && byte_ready_o && !abort_i;
  assign last_byte    = take && (idx_q == 2'd3);
  assign start_ok     = start_i && ((state_q == S_IDLE) || (state_q == S_ERR));
  // Complete word as it will look once the fourth byte lands.
  assign len_word     = {byte_data_i, asm_q[23:0]};

  assign busy_o        = in_busy;
  assign load_enable_o = (state_q == S_WRITE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = error_q;
  assign load_addr_o   = load_addr_q;
  assign load_data_o   = load_data_q;

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LEN;
      S_LEN: begin
        if (abort_i) state_d = S_IDLE;
        else if (last_byte) begin
          if (len_word == 32'd0)          state_d = S_DONE;
          else if (len_word > Capacity)   state_d = S_ERR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (abort_i)        state_d = S_IDLE;
        else if (last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort_i)                    state_d = S_IDLE;
        else if (rem_q == RemW'(1))     state_d = S_DONE;
        else                            state_d = S_DATA;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (start_i) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte assembly, word counting, address stepping and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q       <= '0;
      asm_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      load_addr_q <= '0;
      load_data_q <= '0;
      error_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        idx_q   <= '0;
        addr_q  <= BaseAddr;
        error_q <= 1'b0;
      end
      if (take) begin
        asm_q[{idx_q, 3'b000} +: 8] <= byte_data_i;
        idx_q                       <= idx_q + 2'd1;
      end
      if (in_busy && abort_i) idx_q <= '0;
      if ((state_q == S_LEN) && last_byte) begin
        rem_q <= len_word[RemW-1:0];
        if (len_word > Capacity) error_q <= 1'b1;
      end
      if ((state_q == S_DATA) && last_byte) begin
        load_data_q <= {byte_data_i, asm_q[width_p-9:0]};
        load_addr_q <= addr_q;
      end
      if (state_q == S_WRITE) begin
        addr_q <= addr_q + AddrW'(4);
        rem_q  <= rem_q - RemW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader (depth 16, base address 0).
module tb_instruction_loader;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH*4);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          bvalid = 1'b0;
  logic [7:0]    bdata = 8'h00;
  logic          bready;
  logic          load_en;
  logic [AW-1:0] laddr;
  logic [31:0]   ldata;
  logic          busy;
  logic          done;
  logic          err;

  instruction_loader #(.width_p(32), .depth_p(DEPTH), .base_addr_p(0)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .abort_i(abort),
    .byte_valid_i(bvalid), .byte_data_i(bdata), .byte_ready_o(bready),
    .load_enable_o(load_en), .load_addr_o(laddr), .load_data_o(ldata),
    .busy_o(busy), .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  wr_cnt = 0;
  int  wr_cyc_last = 0;
  int  wr_cyc_prev = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (load_en === 1'b1) begin
      wr_cnt++;
      wr_cyc_prev = wr_cyc_last;
      wr_cyc_last = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected got addr=%h data=%h, expected no write", laddr, ldata);
      end else begin
        exp_w = exp_q.pop_front();
        if (laddr !== exp_w.a || ldata !== exp_w.d) begin
          n_fail++;
          $display("FAIL write_value got addr=%h data=%h, expected addr=%h data=%h",
                   laddr, ldata, exp_w.a, exp_w.d);
        end
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_in_write got %b, expected 1", busy);
      end
      n_checks++;
      if (prev_en === 1'b1) begin
        n_fail++;
        $display("FAIL write_strobe_width got 2+ cycles, expected 1");
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_en = load_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bvalid = 1'b1;
    bdata  = b;
    @(negedge clk);
    while (bready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout got ready=%b, expected 1", bready);
    end
    @(posedge clk);
    #1;
    bvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL done_timeout got no done pulse within %0d cycles, expected one", budget);
    end
  endtask

  // Drives the two-word image used by several scenarios.
  task automatic drive_basic_image();
    exp_q.push_back('{a: AW'(0), d: 32'h00000013});
    exp_q.push_back('{a: AW'(4), d: 32'h00100093});
    send_word(32'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({bready, load_en, busy, done, err, laddr, ldata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b en=%b busy=%b done=%b err=%b addr=%h data=%h, expected all 0",
               bready, load_en, busy, done, err, laddr, ldata);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (bready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got rdy=%b busy=%b, expected 0 0", bready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || bready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_len_state got busy=%b rdy=%b, expected 1 1", busy, bready);
    end
    @(posedge clk);
    #1;
    drive_basic_image();
    wait_done(d0, 20);
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_counts got writes=%0d dones=%0d, expected 2 1", wr_cnt - w0, done_cnt - d0);
    end
    n_checks++;
    if (wr_cyc_last - wr_cyc_prev !== 5) begin
      n_fail++;
      $display("FAIL basic_throughput got %0d cycles/word, expected 5", wr_cyc_last - wr_cyc_prev);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || laddr !== AW'(4) || ldata !== 32'h00100093) begin
      n_fail++;
      $display("FAIL basic_idle_hold got busy=%b done=%b addr=%h data=%h, expected 0 0 04 00100093",
               busy, done, laddr, ldata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_len();
    int d0, w0, s;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    s = cyc;
    send_word(32'd0);
    wait_done(d0, 10);
    tick();
    @(negedge clk);
    n_checks++;
    if (done_cyc !== s + 4) begin
      n_fail++;
      $display("FAIL zero_len_done_timing got cycle %0d, expected %0d", done_cyc, s + 4);
    end
    n_checks++;
    if (wr_cnt !== w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_state got writes=%0d busy=%b, expected 0 0", wr_cnt - w0, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_error();
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    send_word(32'd17);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bready !== 1'b0) begin
      n_fail++;
      $display("FAIL error_set got err=%b busy=%b rdy=%b, expected 1 0 0", err, busy, bready);
    end
    @(posedge clk);
    #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done_cnt !== d0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL error_sticky got err=%b busy=%b dones=%0d writes=%0d, expected 1 0 0 0",
               err, busy, done_cnt - d0, wr_cnt - w0);
    end
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL error_clear got err=%b busy=%b, expected 0 1", err, busy);
    end
    @(posedge clk);
    #1;
    exp_q.push_back('{a: AW'(0), d: 32'hDEADBEEF});
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    wait_done(d0, 20);
    n_checks++;
    if (wr_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL error_recover_writes got %0d, expected 1", wr_cnt - w0);
    end
    // Exactly full memory: 16 words, last address 0x3C.
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    send_word(32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{a: AW'(4*i), d: 32'hA5000000 | (32'(i) * 32'h00010101)});
      send_word(32'hA5000000 | (32'(i) * 32'h00010101));
    end
    wait_done(d0, 40);
    n_checks++;
    if (wr_cnt - w0 !== 16 || err !== 1'b0 || laddr !== AW'(60)) begin
      n_fail++;
      $display("FAIL capacity_boundary got writes=%0d err=%b addr=%h, expected 16 0 3c",
               wr_cnt - w0, err, laddr);
    end
    // Oversize length carried only in the top byte.
    tick();
    pulse_start();
    send_word(32'h01000000);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL error_high_byte got err=%b busy=%b, expected 1 0", err, busy);
    end
    @(posedge clk);
    #1;
    d0 = done_cnt;
    pulse_start();
    send_word(32'd0);
    wait_done(d0, 10);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear_zero got err=%b, expected 0", err);
    end
    tick();
  endtask

  task automatic test_gaps();
    int d0, w0, gap;
    logic [7:0] s [12];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
    d0 = done_cnt;
    w0 = wr_cnt;
    exp_q.push_back('{a: AW'(0), d: 32'h00000013});
    exp_q.push_back('{a: AW'(4), d: 32'h00100093});
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      gap = (i == 6) ? 10 : int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        // A stray start mid-session must be ignored.
        if (i == 6 && g == 5) start = 1'b1;
        @(negedge clk);
        if (i % 4 != 0) begin
          n_checks++;
          if (bready !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_ready byte %0d gap %0d got %b, expected 1", i, g, bready);
          end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send_byte(s[i]);
    end
    wait_done(d0, 20);
    tick();
    n_checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL gaps_counts got writes=%0d dones=%0d, expected 2 1", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    abort  = 1'b1;
    bvalid = 1'b1;
    bdata  = 8'hFF;
    tick();
    abort  = 1'b0;
    bvalid = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bready !== 1'b0 || done_cnt !== d0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL abort_data got busy=%b rdy=%b dones=%0d writes=%0d, expected 0 0 0 0",
               busy, bready, done_cnt - d0, wr_cnt - w0);
    end
    @(posedge clk);
    #1;
    pulse_start();
    drive_basic_image();
    wait_done(d0, 20);
    tick();
    n_checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL abort_realign got writes=%0d dones=%0d, expected 2 1", wr_cnt - w0, done_cnt - d0);
    end
    // Abort during the write cycle: the write lands, then idle without done.
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start();
    exp_q.push_back('{a: AW'(0), d: 32'h11223344});
    send_word(32'd2);
    send_word(32'h11223344);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_cnt - w0 !== 1 || done_cnt !== d0 ||
        laddr !== AW'(0) || ldata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL abort_write got busy=%b writes=%0d dones=%0d addr=%h data=%h, expected 0 1 0 00 11223344",
               busy, wr_cnt - w0, done_cnt - d0, laddr, ldata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int d0, w0;
    pulse_start();
    send_word(32'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bready, load_en, busy, done, err, laddr, ldata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got rdy=%b en=%b busy=%b done=%b err=%b addr=%h data=%h, expected all 0",
               bready, load_en, busy, done, err, laddr, ldata);
    end
    #3;
    reset_n = 1'b1;
    d0 = done_cnt;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle got rdy=%b busy=%b, expected 0 0", bready, busy);
      end
      @(posedge clk);
      #1;
    end
    pulse_start();
    drive_basic_image();
    wait_done(d0, 20);
    tick();
    n_checks++;
    if (wr_cnt - w0 !== 2) begin
      n_fail++;
      $display("FAIL post_reset_session got writes=%0d, expected 2", wr_cnt - w0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_gaps();
    test_abort();
    test_async_reset();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending writes, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
